// File: rtl/ldpc_pkg.sv
// Shared types and defaults for the LDPC layer scheduler and its datapath neighbours.
package ldpc_pkg;

    localparam int DEF_NUM_ROWS    = 12;
    localparam int DEF_CNU_LATENCY = 5;
    localparam int ITER_W          = 4;

    typedef logic [$clog2(DEF_NUM_ROWS)-1:0] row_idx_t;
    typedef logic [ITER_W-1:0]               iter_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

    // An iteration limit of zero still runs one full sweep.
    function automatic iter_t sat_max_iter(input iter_t raw);
        return (raw == '0) ? iter_t'(1) : raw;
    endfunction

endpackage

// File: rtl/ldpc_layer_scheduler_if.sv
// Control, CNU issue and write-back signals between decoder control, the scheduler and the CNU/LLR datapath.
interface ldpc_layer_scheduler_if #(
    parameter int ROW_W = 4
);
    import ldpc_pkg::*;

    // Handshake: a row is issued exactly in a cycle with o_cnu_valid high, which only
    // happens while i_mem_ready is high; there is no other backpressure. o_wb_valid
    // marks a write-back cycle and i_syndrome_fail is only meaningful in those cycles.
    logic              i_start;
    iter_t             i_max_iter;
    logic              i_abort;
    logic              i_mem_ready;
    logic              i_syndrome_fail;
    logic              o_busy;
    logic              o_cnu_valid;
    logic [ROW_W-1:0]  o_cnu_row;
    logic              o_wb_valid;
    logic [ROW_W-1:0]  o_wb_row;
    logic              o_done;
    logic              o_converged;
    iter_t             o_iter_count;

    modport master (
        output i_start, i_max_iter, i_abort, i_mem_ready, i_syndrome_fail,
        input  o_busy, o_cnu_valid, o_cnu_row, o_wb_valid, o_wb_row,
               o_done, o_converged, o_iter_count
    );

    modport slave (
        input  i_start, i_max_iter, i_abort, i_mem_ready, i_syndrome_fail,
        output o_busy, o_cnu_valid, o_cnu_row, o_wb_valid, o_wb_row,
               o_done, o_converged, o_iter_count
    );

endinterface

// File: rtl/ldpc_delay_line.sv
// Fixed-depth shift register modelling CNU pipeline occupancy; the MSB of each entry is its valid bit.
module ldpc_delay_line #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 5
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_any_valid
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_reset || i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign o_data = stage_q[DEPTH-1];

    // Only entries not yet at the output count: the entry at the output is being
    // written back this cycle, so the caller may move on once nothing else is queued.
    always_comb begin
        o_any_valid = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            o_any_valid = o_any_valid | stage_q[i][WIDTH-1];
        end
    end

endmodule

// File: rtl/ldpc_layer_scheduler.sv
// Layered LDPC iteration sequencer: issues check rows to the CNU, tracks write-back, and decides convergence.
module ldpc_layer_scheduler
    import ldpc_pkg::*;
#(
    parameter int NUM_ROWS    = DEF_NUM_ROWS,
    parameter int CNU_LATENCY = DEF_CNU_LATENCY
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    ldpc_layer_scheduler_if.slave bus,
    output sched_state_t          o_state
);

    localparam int              ROW_W    = $clog2(NUM_ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    sched_state_t     state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    iter_t            max_q, max_d;
    iter_t            iter_q, iter_d;
    logic             fail_q, fail_d;
    logic             conv_q, conv_d;

    logic             cnu_valid;
    logic             flush;
    logic             in_flight;
    logic [ROW_W:0]   wb_word;
    logic             wb_valid;
    logic [ROW_W-1:0] wb_row;

    ldpc_delay_line #(
        .DEPTH (CNU_LATENCY),
        .WIDTH (ROW_W + 1)
    ) u_delay_line (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_flush     (flush),
        .i_data      ({cnu_valid, row_q}),
        .o_data      (wb_word),
        .o_any_valid (in_flight)
    );

    assign wb_valid = wb_word[ROW_W];
    assign wb_row   = wb_word[ROW_W-1:0];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            max_q   <= '0;
            iter_q  <= '0;
            fail_q  <= 1'b0;
            conv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            max_q   <= max_d;
            iter_q  <= iter_d;
            fail_q  <= fail_d;
            conv_q  <= conv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        max_d     = max_q;
        iter_d    = iter_q;
        fail_d    = fail_q;
        conv_d    = conv_q;
        cnu_valid = 1'b0;
        flush     = 1'b0;

        if (wb_valid && bus.i_syndrome_fail) begin
            fail_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d = ST_ISSUE;
                    max_d   = sat_max_iter(bus.i_max_iter);
                    iter_d  = '0;
                    row_d   = '0;
                    fail_d  = 1'b0;
                    conv_d  = 1'b0;
                end
            end
            ST_ISSUE: begin
                cnu_valid = bus.i_mem_ready;
                if (bus.i_mem_ready) begin
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Hold off the next sweep until every issued row has reached write-back.
                if (!in_flight) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                iter_d = iter_q + iter_t'(1);
                if (!fail_q) begin
                    state_d = ST_DONE;
                    conv_d  = 1'b1;
                end else if (iter_d == max_q) begin
                    state_d = ST_DONE;
                    conv_d  = 1'b0;
                end else begin
                    state_d = ST_ISSUE;
                    fail_d  = 1'b0;
                    row_d   = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An abandoned decode leaves no result behind and does not count a partial iteration.
        if (bus.i_abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            flush   = 1'b1;
            conv_d  = 1'b0;
            iter_d  = iter_q;
        end
    end

    assign bus.o_busy       = (state_q == ST_ISSUE) || (state_q == ST_DRAIN) || (state_q == ST_CHECK);
    assign bus.o_cnu_valid  = cnu_valid;
    assign bus.o_cnu_row    = row_q;
    assign bus.o_wb_valid   = wb_valid;
    assign bus.o_wb_row     = wb_row;
    assign bus.o_done       = (state_q == ST_DONE);
    assign bus.o_converged  = conv_q;
    assign bus.o_iter_count = iter_q;
    assign o_state          = state_q;

endmodule

// File: tb/tb_ldpc_layer_scheduler.sv
// Bench for ldpc_layer_scheduler: timestamp-based reference model, directed scenarios and randomized decodes.
module tb_ldpc_layer_scheduler;
    import ldpc_pkg::*;

    localparam int NUM_ROWS = 12;
    localparam int LAT      = 5;
    localparam int ROW_W    = $clog2(NUM_ROWS);

    logic         i_clock = 1'b0;
    logic         i_reset = 1'b1;
    sched_state_t dbg_state;

    ldpc_layer_scheduler_if #(.ROW_W(ROW_W)) bus ();

    ldpc_layer_scheduler #(
        .NUM_ROWS    (NUM_ROWS),
        .CNU_LATENCY (LAT)
    ) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus.slave),
        .o_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 i_clock = ~i_clock;

    int cyc = 0;
    always @(posedge i_clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask

    // ---------------- stimulus knobs ----------------
    int start_at     = -1;
    int dup_start_at = -1;
    int abort_at     = -1;
    int knob_max     = 0;
    int ready_mode   = 0;   // 0: always ready, 1: random, 2: stall window
    int stall_from   = -1;
    int stall_to     = -1;
    int fail_row     = -1;
    int fail_left    = 0;
    bit fail_rand    = 0;
    bit abort_rand   = 0;

    // ---------------- driver ----------------
    initial begin
        bus.i_start         = 1'b0;
        bus.i_max_iter      = '0;
        bus.i_abort         = 1'b0;
        bus.i_mem_ready     = 1'b0;
        bus.i_syndrome_fail = 1'b0;
        forever begin
            @(posedge i_clock);
            #1;
            bus.i_start    = (cyc == start_at) || (cyc == dup_start_at);
            bus.i_max_iter = (cyc == start_at) ? iter_t'(knob_max) : iter_t'($urandom_range(0, 15));
            case (ready_mode)
                0:       bus.i_mem_ready = 1'b1;
                1:       bus.i_mem_ready = ($urandom_range(0, 4) != 0);
                default: bus.i_mem_ready = !((cyc >= stall_from) && (cyc < stall_to));
            endcase
            if (bus.o_wb_valid && (int'(bus.o_wb_row) == fail_row) && (fail_left > 0)) begin
                bus.i_syndrome_fail = 1'b1;
                fail_left--;
            end else if (fail_rand) begin
                bus.i_syndrome_fail = ($urandom_range(0, 15) == 0);
            end else begin
                bus.i_syndrome_fail = !bus.o_wb_valid && ($urandom_range(0, 2) == 0);
            end
            bus.i_abort = (cyc == abort_at) || (abort_rand && ($urandom_range(0, 299) == 0));
        end
    end

    // ---------------- reference model (event timestamps) ----------------
    bit              model_en = 0;
    bit              m_act = 0;
    int              m_row = 0;
    int              m_issue_from = 0;
    int              m_check = -1;
    int              m_done = -1;
    int              m_iters = 0;
    int              m_iter_out = 0;
    int              m_max = 1;
    bit              m_fail = 0;
    bit              m_conv = 0;
    logic [ROW_W-1:0] exp_q[$];
    int              due_q[$];
    int              done_seen = -1;
    int              last_wb_final = -1;

    bit was_act, issuing, ev, ewb;

    always @(negedge i_clock) begin
        if (model_en) begin
            was_act = m_act;
            issuing = m_act && (m_row < NUM_ROWS) && (cyc >= m_issue_from);
            ev      = issuing && bus.i_mem_ready;
            ewb     = (due_q.size() > 0) && (due_q[0] == cyc);

            chk("cnu_valid", bus.o_cnu_valid, ev);
            if (issuing) chk("cnu_row", bus.o_cnu_row, m_row);
            chk("wb_valid", bus.o_wb_valid, ewb);
            if (ewb) chk("wb_row", bus.o_wb_row, exp_q[0]);
            chk("busy", bus.o_busy, m_act && (cyc != m_done));
            chk("done", bus.o_done, m_act && (cyc == m_done));
            chk("converged", bus.o_converged, m_conv);
            chk("iter_count", bus.o_iter_count, m_iter_out);

            if (bus.o_wb_valid && (int'(bus.o_wb_row) == NUM_ROWS - 1)) last_wb_final = cyc;
            if (bus.o_cnu_valid && (bus.o_cnu_row == '0)) chk("row0_after_last_wb", cyc > last_wb_final, 1);
            if (bus.o_done) done_seen = cyc;

            if (i_reset) begin
                m_act = 0; m_conv = 0; m_iter_out = 0; m_fail = 0;
                exp_q.delete(); due_q.delete();
            end else if (was_act && bus.i_abort) begin
                m_act = 0; m_conv = 0;
                exp_q.delete(); due_q.delete();
            end else begin
                if (ewb) begin
                    if (bus.i_syndrome_fail) m_fail = 1;
                    void'(exp_q.pop_front());
                    void'(due_q.pop_front());
                end
                if (ev) begin
                    exp_q.push_back(ROW_W'(m_row));
                    due_q.push_back(cyc + LAT);
                    m_row++;
                    if (m_row == NUM_ROWS) m_check = cyc + LAT + 1;
                end
                if (m_act && (cyc == m_check)) begin
                    m_iters++;
                    m_iter_out = m_iters;
                    if (!m_fail || (m_iters == m_max)) begin
                        m_done = cyc + 1;
                        m_conv = !m_fail;
                    end else begin
                        m_fail       = 0;
                        m_row        = 0;
                        m_issue_from = cyc + 1;
                    end
                end
                if (was_act && (cyc == m_done)) m_act = 0;
                if (!was_act && bus.i_start) begin
                    m_act = 1; m_row = 0; m_issue_from = cyc + 1;
                    m_check = -1; m_done = -1; m_iters = 0; m_iter_out = 0;
                    m_fail = 0; m_conv = 0;
                    m_max = (bus.i_max_iter == '0) ? 1 : int'(bus.i_max_iter);
                end
            end
        end
    end

    // ---------------- test sequencing ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clock);
            #1;
        end
    endtask

    task automatic start_decode(input int mx);
        knob_max  = mx;
        done_seen = -1;
        start_at  = cyc + 1;
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while ((done_seen < 0) && (n < bound)) begin
            @(negedge i_clock);
            #1;
            n++;
        end
        if (done_seen < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout cycle=%0d got=no_done expected=done within %0d cycles", cyc, bound);
        end
    endtask

    task automatic run_fixed(input string name, input int mx, input int frow, input int fleft,
                             input int exp_off, input int exp_iter, input int exp_conv);
        fail_row  = frow;
        fail_left = fleft;
        start_decode(mx);
        wait_done(600);
        chk({name, "_done_at"}, done_seen - start_at, exp_off);
        chk({name, "_iter"}, bus.o_iter_count, exp_iter);
        chk({name, "_conv"}, bus.o_converged, exp_conv);
        idle(3);
        chk({name, "_conv_held"}, bus.o_converged, exp_conv);
        fail_row  = -1;
        fail_left = 0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge i_clock);
        #1;
        i_reset  = 1'b0;
        model_en = 1'b1;
        idle(1);
        chk("reset_state", dbg_state, ST_IDLE);
        chk("reset_busy", bus.o_busy, 0);
        chk("reset_cnu_valid", bus.o_cnu_valid, 0);
        chk("reset_wb_valid", bus.o_wb_valid, 0);
        chk("reset_done", bus.o_done, 0);
        chk("reset_iter", bus.o_iter_count, 0);
        chk("reset_conv", bus.o_converged, 0);
        idle(2);

        run_fixed("converge_first", 4, -1, 0, 19, 1, 1);
        run_fixed("iter_limit", 3, 3, 99, 55, 3, 0);
        run_fixed("late_converge", 8, 11, 2, 55, 3, 1);

        ready_mode = 2;
        stall_from = cyc + 1 + 7;
        stall_to   = stall_from + 4;
        run_fixed("mem_stall", 4, -1, 0, 23, 1, 1);
        ready_mode = 0;

        start_decode(4);
        abort_at = start_at + 15;
        idle(25);
        chk("abort_no_done", done_seen, -1);
        chk("abort_busy", bus.o_busy, 0);
        chk("abort_conv", bus.o_converged, 0);
        abort_at = -1;
        run_fixed("after_abort", 4, -1, 0, 19, 1, 1);

        fail_row  = 0;
        fail_left = 1;
        start_decode(0);
        dup_start_at = start_at + 5;
        wait_done(600);
        chk("max0_done_at", done_seen - start_at, 19);
        chk("max0_iter", bus.o_iter_count, 1);
        chk("max0_conv", bus.o_converged, 0);
        dup_start_at = -1;
        fail_row     = -1;
        fail_left    = 0;
        idle(3);

        start_decode(4);
        idle(8);
        @(posedge i_clock);
        #1;
        i_reset = 1'b1;
        @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        @(negedge i_clock);
        #1;
        chk("midreset_state", dbg_state, ST_IDLE);
        chk("midreset_busy", bus.o_busy, 0);
        chk("midreset_cnu_valid", bus.o_cnu_valid, 0);
        chk("midreset_wb_valid", bus.o_wb_valid, 0);
        chk("midreset_iter", bus.o_iter_count, 0);
        idle(3);

        ready_mode = 1;
        fail_rand  = 1;
        abort_rand = 1;
        for (int k = 0; k < 25; k++) begin
            start_decode($urandom_range(0, 15));
            dup_start_at = start_at + $urandom_range(2, 60);
            n = 0;
            while (!((cyc > start_at) && !m_act) && (n < 1500)) begin
                @(negedge i_clock);
                #1;
                n++;
            end
            if (n >= 1500) begin
                checks++;
                errors++;
                $display("FAIL random_timeout cycle=%0d got=busy expected=idle within 1500 cycles", cyc);
            end
            idle($urandom_range(1, 4));
        end
        abort_rand   = 0;
        dup_start_at = -1;
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
